boot_memory: RTL and testbench

BOOT_MEMORY -- requirements
Module: boot_memory

---
 rtl/boot_memory.sv | 122 ++++++++++++
 tb/tb_boot_memory.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/boot_memory.sv
// Boot loader memory: takes a length/data/checksum byte stream, then
// holds the CPU in reset until a good image is in place.
module boot_memory #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        load_data,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              reload,
  input  logic [ADDR_W-1:0] Mem_ADDR,
  input  logic [7:0]        Mem_IN,
  input  logic              write,
  output logic [7:0]        Mem_OUT,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_LEN,
    S_LOAD,
    S_CHK,
    S_RUN,
    S_ERR
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     count, count_n;
  logic [ADDR_W-1:0] load_addr, addr_n;
  logic [7:0]        sum, sum_n;
  logic [7:0]        chk_sum;
  logic              xfer;

  logic [7:0]        mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [7:0]        mem_wd;

  assign load_ready = (state == S_LEN) ||
                      (state == S_LOAD) ||
                      (state == S_CHK);
  assign xfer    = load_valid & load_ready;
  assign chk_sum = sum + load_data;
  assign done    = (state == S_RUN);
  assign err     = (state == S_ERR);
  assign Mem_OUT = mem[Mem_ADDR];

  // Next-state, loader datapath and the single memory write port mux.
  always_comb begin
    state_n = state;
    count_n = count;
    addr_n  = load_addr;
    sum_n   = sum;
    mem_we  = 1'b0;
    mem_wa  = load_addr;
    mem_wd  = load_data;
    unique case (state)
      S_LEN: begin
        if (xfer) begin
          // A length of zero stands for a full-depth image.
          count_n = (load_data == 8'd0) ? FULL : CW'(load_data);
          addr_n  = '0;
          sum_n   = '0;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          mem_we  = 1'b1;
          sum_n   = chk_sum;
          addr_n  = load_addr + ADDR_W'(1);
          count_n = count - CW'(1);
          if (count == CW'(1)) state_n = S_CHK;
        end
      end
      S_CHK: begin
        if (xfer) state_n = (chk_sum == 8'd0) ? S_RUN : S_ERR;
      end
      S_RUN: begin
        if (write) begin
          mem_we = 1'b1;
          mem_wa = Mem_ADDR;
          mem_wd = Mem_IN;
        end
        if (reload) state_n = S_LEN;
      end
      S_ERR: begin
        if (reload) state_n = S_LEN;
      end
      default: state_n = S_LEN;
    endcase
  end

  // Control state; cpu_reset is registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_LEN;
      count     <= '0;
      load_addr <= '0;
      sum       <= '0;
      cpu_reset <= 1'b1;
    end else begin
      state     <= state_n;
      count     <= count_n;
      load_addr <= addr_n;
      sum       <= sum_n;
      cpu_reset <= (state_n != S_RUN);
    end
  end

  // Memory array keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

endmodule

// File: tb/tb_boot_memory.sv
// Directed bench for boot_memory: load, checksum, CPU access,
// reload, gaps, full-depth image and asynchronous reset.
module tb_boot_memory;

  logic       clk;
  logic       reset;
  logic [7:0] load_data;
  logic       load_valid;
  logic       load_ready;
  logic       reload;
  logic [7:0] Mem_ADDR;
  logic [7:0] Mem_IN;
  logic       write;
  logic [7:0] Mem_OUT;
  logic       cpu_reset;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  boot_memory #(.ADDR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .reload     (reload),
    .Mem_ADDR   (Mem_ADDR),
    .Mem_IN     (Mem_IN),
    .write      (write),
    .Mem_OUT    (Mem_OUT),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    load_data  = b;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic peek(input string tag,
                      input logic [7:0] a,
                      input logic [7:0] exp);
    Mem_ADDR = a;
    #1;
    chk(tag, Mem_OUT, exp);
  endtask

  task automatic status(input string tag,
                        input logic rdy,
                        input logic cr,
                        input logic dn,
                        input logic er);
    chk({tag, ".ready"}, load_ready, rdy);
    chk({tag, ".cpu_reset"}, cpu_reset, cr);
    chk({tag, ".done"}, done, dn);
    chk({tag, ".err"}, err, er);
  endtask

  initial begin
    reset      = 1'b1;
    load_data  = 8'h00;
    load_valid = 1'b0;
    reload     = 1'b0;
    Mem_ADDR   = 8'h00;
    Mem_IN     = 8'h00;
    write      = 1'b0;
    #1;
    status("reset", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // 0x11+0x22+0x33 = 0x66; closing byte CC leaves 0x32, a bad sum.
    send(8'h03);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'hCC);
    status("bad_cc", 1'b0, 1'b1, 1'b0, 1'b1);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    status("reload_err", 1'b1, 1'b1, 1'b0, 1'b0);

    // Same image with the correct checksum 0x9A.
    send(8'h03);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    chk("pre_chk.cpu_reset", cpu_reset, 1'b1);
    send(8'h9A);
    status("good", 1'b0, 1'b0, 1'b1, 1'b0);
    peek("good.mem0", 8'h00, 8'h11);
    peek("good.mem1", 8'h01, 8'h22);
    peek("good.mem2", 8'h02, 8'h33);

    // CPU write in S_RUN.
    Mem_ADDR = 8'h05;
    Mem_IN   = 8'hA5;
    write    = 1'b1;
    tick();
    write = 1'b0;
    chk("run_write", Mem_OUT, 8'hA5);

    // Stream bytes are ignored while running.
    send(8'h77);
    peek("run_ignore.mem0", 8'h00, 8'h11);
    chk("run_ignore.done", done, 1'b1);

    // Reload with a same-cycle CPU write: write lands.
    Mem_ADDR = 8'h06;
    Mem_IN   = 8'h5A;
    write    = 1'b1;
    reload   = 1'b1;
    tick();
    write  = 1'b0;
    reload = 1'b0;
    status("reload_run", 1'b1, 1'b1, 1'b0, 1'b0);
    peek("reload_run.mem6", 8'h06, 8'h5A);

    // Bad checksum: 01+02+00 = 03.
    send(8'h02);
    send(8'h01);
    send(8'h02);
    send(8'h00);
    status("bad", 1'b0, 1'b1, 1'b0, 1'b1);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    status("reload_bad", 1'b1, 1'b1, 1'b0, 1'b0);

    // CPU write and reload during S_LOAD are both ignored.
    send(8'h02);
    Mem_ADDR = 8'h05;
    Mem_IN   = 8'h3C;
    write    = 1'b1;
    tick();
    write = 1'b0;
    peek("load_write.mem5", 8'h05, 8'hA5);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    send(8'h10);
    send(8'h20);
    chk("load_reload.done", done, 1'b0);
    send(8'hD0);
    status("load_reload", 1'b0, 1'b0, 1'b1, 1'b0);
    peek("load_reload.mem0", 8'h00, 8'h10);
    peek("load_reload.mem1", 8'h01, 8'h20);

    // Gapped stream 01,40,C0 with three idle cycles between bytes.
    reload = 1'b1;
    tick();
    reload = 1'b0;
    send(8'h01);
    repeat (3) tick();
    send(8'h40);
    repeat (3) tick();
    status("gap_hold", 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'hC0);
    status("gap", 1'b0, 1'b0, 1'b1, 1'b0);
    peek("gap.mem0", 8'h00, 8'h40);
    peek("gap.mem1", 8'h01, 8'h20);
    peek("gap.mem2", 8'h02, 8'h33);

    // Full depth: N=00, bytes 0..255, sum 0x7F80 -> checksum 0x80.
    reload = 1'b1;
    tick();
    reload = 1'b0;
    send(8'h00);
    for (int i = 0; i < 256; i++) send(8'(i));
    status("full_pre", 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'h80);
    status("full", 1'b0, 1'b0, 1'b1, 1'b0);
    peek("full.mem255", 8'hFF, 8'hFF);
    peek("full.mem0", 8'h00, 8'h00);
    peek("full.mem128", 8'h80, 8'h80);

    // Asynchronous reset out of S_RUN, between edges.
    #2;
    reset = 1'b1;
    #1;
    status("areset_run", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    reset = 1'b0;

    // Reset after two of three data bytes.
    send(8'h03);
    send(8'hAA);
    send(8'hBB);
    #2;
    reset = 1'b1;
    #1;
    status("areset_load", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    peek("areset.mem0", 8'h00, 8'hAA);
    peek("areset.mem1", 8'h01, 8'hBB);
    peek("areset.mem2", 8'h02, 8'h02);
    send(8'h01);
    peek("relen.mem1", 8'h01, 8'hBB);
    send(8'h5E);
    send(8'hA2);
    status("relen", 1'b0, 1'b0, 1'b1, 1'b0);
    peek("relen.mem0", 8'h00, 8'h5E);
    peek("relen.mem1b", 8'h01, 8'hBB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
